addsub_multicycle: RTL

Multi-cycle, parametrised adder/subtracter for the datapath ALU. Processes a WIDTH-bit add or subtract in SLICE-bit slices, one slice per clock, keeping the inter-slice carry in a register. This trades latency for a short carry chain. It keeps the established flag semantics: carry/borrow, signed overflow, zero, and a WIDTH+1-bit sign-corrected result. A start/busy/done handshake connects it to the control FSM.

---
 rtl/addsub_multicycle.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/addsub_multicycle.sv
// addsub_multicycle: WIDTH-bit add/subtract evaluated SLICE bits per clock.
// The inter-slice carry lives in a register, so the critical path is one
// SLICE-bit adder. Optional feature macro: ADDSUB_SATURATE_EN (clamp on
// signed overflow); without it the result wraps in two's complement.
// WIDTH must be a positive multiple of SLICE, and WIDTH must be at least 2.
module addsub_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned LO_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_acc;

    logic               w_accept;
    logic               w_last;
    logic [LO_W-1:0]    w_lo;
    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE:0]     w_sum_ext;
    logic [SLICE-1:0]   w_sum;
    logic               w_cout;
    logic               w_cin_msb;
    logic               w_ovf;
    logic               w_sign;
    logic [WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]   w_res_lo;
    logic [WIDTH:0]     w_res;

    // A new request is taken whenever no slices are in flight.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Current slice operands; subtract uses A + ~B + 1 with the +1 preloaded as carry.
    assign w_lo      = LO_W'(r_idx) * LO_W'(SLICE);
    assign w_a_sl    = r_a[w_lo +: SLICE];
    assign w_b_sl    = r_b[w_lo +: SLICE] ^ {SLICE{r_mode}};
    assign w_sum_ext = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(r_carry);
    assign w_sum     = w_sum_ext[SLICE-1:0];
    assign w_cout    = w_sum_ext[SLICE];

    // Carry into the operand MSB recovered from the MSB sum bit; only meaningful on the last slice.
    assign w_cin_msb = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1];
    assign w_ovf     = w_cin_msb ^ w_cout;

    // Accumulator with the current slice merged in, i.e. the full sum on the last slice.
    always_comb begin
        w_full = r_acc;
        w_full[w_lo +: SLICE] = w_sum;
    end

    // True sign of the infinitely-precise result.
    assign w_sign = w_full[WIDTH-1] ^ w_ovf;

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp the low WIDTH bits toward the true sign on overflow.
    always_comb begin
        w_res_lo = w_full;
        if (w_ovf) begin
            w_res_lo = w_sign ? SAT_MIN : SAT_MAX;
        end
    end
`else
    // Wrapping result.
    always_comb begin
        w_res_lo = w_full;
    end
`endif

    assign w_res = {w_sign, w_res_lo};

    // Operand capture and per-slice accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= mode;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_full;
            r_carry <= w_cout;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // Result and flags are loaded together on the last slice and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            result   <= w_res;
            carry    <= w_cout ^ r_mode;
            overflow <= w_ovf;
            zero     <= (w_res == '0);
            negative <= w_sign;
        end
    end

    // Handshake outputs registered from the next state so they track RUN/DONE exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (w_next == S_RUN);
            done <= (w_next == S_DONE);
        end
    end

endmodule
